// File: rtl/gate_op_arbiter_pkg.sv
// Shared types and the gate truth function for gate_op_arbiter.
//   gate_op_e   : 3-bit opcode (AND, OR, XOR, NAND, NOR, NOT a, BUF a, XNOR)
//   arb_state_e : arbiter FSM state (IDLE, EXEC, RESP)
//   gate_eval   : evaluates one opcode on two operand bits
package gate_arb_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_NOT  = 3'd5,
    OP_BUF  = 3'd6,
    OP_XNOR = 3'd7
  } gate_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // NOT and BUF look at operand a only.
  function automatic logic gate_eval(gate_op_e op, logic a, logic b);
    logic y;
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      OP_BUF:  y = a;
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle between NREQ requesters, one result consumer and gate_op_arbiter.
//   req_valid/req_ready : per-requester handshake (req_ready is one-hot)
//   req_op/req_a/req_b  : opcode of req i at [3i+2:3i], operand bits at [i]
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_data     : owning requester index and gate result
//   busy                : arbiter not idle
// Modports: slave = arbiter side, master = requester/consumer side.
interface gate_op_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [NREQ-1:0]   req_a;
  logic [NREQ-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_data;
  logic              busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/gate_op_unit.sv
// Combinational 1-bit gate unit; the single resource shared by all requesters.
//   op : opcode (gate_op_e)
//   a  : operand a
//   b  : operand b (ignored for NOT/BUF)
//   y  : result
module gate_op_unit
  import gate_arb_pkg::*;
(
  input  gate_op_e op,
  input  logic     a,
  input  logic     b,
  output logic     y
);

  assign y = gate_eval(op, a, b);

endmodule

// File: rtl/gate_op_arbiter.sv
// Arbitrates NREQ requesters onto one registered gate unit.
// FSM IDLE -> EXEC -> RESP -> IDLE; accept in cycle N gives rsp_valid in cycle N+2.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : gate_op_arbiter_if.slave (requests, response, busy)
// Build option GATE_ARB_RR_EN: round-robin arbitration starting after the last winner;
// otherwise fixed priority with the lowest index winning.
module gate_op_arbiter
  import gate_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  gate_op_arbiter_if.slave    bus
);

  arb_state_e     state_q, state_d;
  gate_op_e       op_q;
  logic           a_q, b_q;
  logic [IDW-1:0] id_q;
  logic           rsp_data_q;
  logic [IDW-1:0] rsp_id_q;

  logic           found;
  logic [IDW-1:0] win_idx;
  logic           accept;
  gate_op_e       sel_op;
  logic           sel_a, sel_b;
  logic           unit_y;

`ifdef GATE_ARB_RR_EN
  logic [IDW-1:0] rr_ptr_q;

  // Search begins one past the previous winner so every requester gets a turn.
  always_comb begin
    int unsigned tgt;
    found   = 1'b0;
    win_idx = '0;
    tgt     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      tgt = (32'(rr_ptr_q) + k) % NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && (i == tgt) && bus.req_valid[i]) begin
          found   = 1'b1;
          win_idx = IDW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= IDW'(NREQ - 1);
    end else if (accept) begin
      rr_ptr_q <= win_idx;
    end
  end
`else
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found   = 1'b1;
        win_idx = IDW'(i);
      end
    end
  end
`endif

  // Operand mux for the winning requester.
  always_comb begin
    sel_op = OP_AND;
    sel_a  = 1'b0;
    sel_b  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_op = gate_op_e'(bus.req_op[3*i +: 3]);
        sel_a  = bus.req_a[i];
        sel_b  = bus.req_b[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    accept        = (state_q == IDLE) && found;
    bus.rsp_valid = (state_q == RESP);
    bus.busy      = (state_q != IDLE);
    bus.req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = accept && (win_idx == IDW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= OP_AND;
      a_q  <= 1'b0;
      b_q  <= 1'b0;
      id_q <= '0;
    end else if (accept) begin
      op_q <= sel_op;
      a_q  <= sel_a;
      b_q  <= sel_b;
      id_q <= win_idx;
    end
  end

  gate_op_unit u_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (unit_y)
  );

  // Result registers load only in EXEC, so they stay stable through RESP backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data_q <= 1'b0;
      rsp_id_q   <= '0;
    end else if (state_q == EXEC) begin
      rsp_data_q <= unit_y;
      rsp_id_q   <= id_q;
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed self-checking bench for gate_op_arbiter with NREQ=2.
module tb_gate_op_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  gate_op_arbiter_if #(.NREQ(2)) bus ();

  gate_op_arbiter #(.NREQ(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full accept/execute/respond sequence; entered and left on a falling edge in IDLE.
  task automatic op_cycle(input int idx, input logic [2:0] op, input logic a, input logic b,
                          input logic exp);
    bus.req_valid           = '0;
    bus.req_valid[idx]      = 1'b1;
    bus.req_op[3*idx +: 3]  = op;
    bus.req_a[idx]          = a;
    bus.req_b[idx]          = b;
    #1;
    check("accept_ready", 32'(bus.req_ready), 32'(1) << idx);
    @(negedge clk);
    bus.req_valid = '0;
    check("exec_busy", 32'(bus.busy), 1);
    check("exec_rsp_valid", 32'(bus.rsp_valid), 0);
    check("exec_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 1);
    check("rsp_data", 32'(bus.rsp_data), 32'(exp));
    check("rsp_id", 32'(bus.rsp_id), 32'(idx));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(bus.rsp_valid), 0);
    check("post_busy", 32'(bus.busy), 0);
  endtask

  // Truth table per opcode, bit index {a,b}.
  logic [3:0] tt [8];
  int         exp_g [4];

  initial begin
    total  = 0;
    passed = 0;
    tt[0] = 4'b1000; // AND
    tt[1] = 4'b1110; // OR
    tt[2] = 4'b0110; // XOR
    tt[3] = 4'b0111; // NAND
    tt[4] = 4'b0001; // NOR
    tt[5] = 4'b0011; // NOT a
    tt[6] = 4'b1100; // BUF a
    tt[7] = 4'b1001; // XNOR
`ifdef GATE_ARB_RR_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
    exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #1;
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_rsp_data", 32'(bus.rsp_data), 0);
    check("reset_rsp_id", 32'(bus.rsp_id), 0);
    check("reset_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single ops from req0: NOR 0,0 -> 1 and NOR 1,0 -> 0.
    op_cycle(0, 3'd4, 1'b0, 1'b0, 1'b1);
    op_cycle(0, 3'd4, 1'b1, 1'b0, 1'b0);

    // Opcode sweep from req1; last op is XNOR 1,1 -> 1 with id 1.
    for (int o = 0; o < 8; o++) begin
      for (int p = 0; p < 4; p++) begin
        op_cycle(1, 3'(o), p[1], p[0], tt[o][p]);
      end
    end

    // Backpressure: AND 1,1 from req0 held in RESP for 5 cycles with both requests valid.
    bus.req_valid    = 2'b01;
    bus.req_op[2:0]  = 3'd0;
    bus.req_a[0]     = 1'b1;
    bus.req_b[0]     = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      check("bp_rsp_data", 32'(bus.rsp_data), 1);
      check("bp_rsp_id", 32'(bus.rsp_id), 0);
      check("bp_ready", 32'(bus.req_ready), 0);
      check("bp_busy", 32'(bus.busy), 1);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_release_busy", 32'(bus.busy), 0);
    check("bp_release_valid", 32'(bus.rsp_valid), 0);

    // Sweep left rsp_data=1, rsp_id=1 behind; run an op then reset in EXEC.
    op_cycle(1, 3'd7, 1'b1, 1'b1, 1'b1);
    bus.req_valid   = 2'b01;
    bus.req_op[2:0] = 3'd1;
    bus.req_a[0]    = 1'b1;
    bus.req_b[0]    = 1'b0;
    @(negedge clk);
    bus.req_valid = '0;
    check("pre_reset_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    check("mid_reset_busy", 32'(bus.busy), 0);
    check("mid_reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("mid_reset_rsp_data", 32'(bus.rsp_data), 0);
    check("mid_reset_rsp_id", 32'(bus.rsp_id), 0);
    check("mid_reset_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("after_reset_no_rsp", 32'(bus.rsp_valid), 0);
      check("after_reset_idle", 32'(bus.busy), 0);
    end

    // Contention straight after reset: both valid every cycle.
    bus.req_valid = 2'b11;
    bus.req_op    = {3'd1, 3'd0};
    bus.req_a     = 2'b11;
    bus.req_b     = 2'b01;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_grant", 32'(bus.req_ready), 32'(1) << exp_g[k]);
      @(negedge clk);
      @(negedge clk);
      check("cont_rsp_valid", 32'(bus.rsp_valid), 1);
      check("cont_rsp_id", 32'(bus.rsp_id), 32'(exp_g[k]));
      // req0: AND 1,1 -> 1; req1: OR 1,0 -> 1
      check("cont_rsp_data", 32'(bus.rsp_data), 1);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);

    // Withdrawal: req1 pulses valid only while the arbiter is in EXEC.
    bus.req_valid   = 2'b01;
    bus.req_op[2:0] = 3'd4;
    bus.req_a[0]    = 1'b0;
    bus.req_b[0]    = 1'b0;
    @(negedge clk);
    bus.req_valid = 2'b10;
    #1;
    check("wd_exec_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    bus.req_valid = '0;
    check("wd_rsp_id", 32'(bus.rsp_id), 0);
    check("wd_rsp_data", 32'(bus.rsp_data), 1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("wd_idle", 32'(bus.busy), 0);
      check("wd_no_rsp", 32'(bus.rsp_valid), 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
